// File: rtl/pe_array_pkg.sv
// Shared definitions for the input-stationary PE array.
// Provides default lane geometry and the psum drain FSM state encoding.
package pe_array_pkg;

    localparam int unsigned PSUM_WIDTH_DEF = 16;
    localparam int unsigned COLS_DEF       = 4;

    // Psum drain frame state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/pe_row_fifo.sv
// Synchronous result-row FIFO with a registered head word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push/wdata  write request and row; dropped when full unless popping in the same cycle
//   pop         read request; ignored when empty
//   rdata       head row, registered, valid while not_empty=1
//   not_empty   registered non-empty flag
//   afull       registered flag, count >= AFULL_LEVEL
//   count       registered fill level, 0..DEPTH
module pe_row_fifo #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     not_empty,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_d;
    logic             do_push, do_pop;

    // Accept a push while full only when a pop frees the slot in the same cycle
    always_comb begin
        do_pop  = pop & not_empty;
        do_push = push & ((count != CW'(DEPTH)) | do_pop);
        count_d = count + CW'(do_push) - CW'(do_pop);
        head_d  = rdata;
        if (do_pop) begin
            if (count > CW'(1)) begin
                head_d = mem[rd_ptr_q + AW'(1)];
            end else if (do_push) begin
                head_d = wdata;
            end
        end else if ((count == '0) && do_push) begin
            head_d = wdata;
        end
    end

    // Storage array, no reset needed: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers, fill level and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count     <= '0;
            rdata     <= '0;
            not_empty <= 1'b0;
            afull     <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count     <= count_d;
            rdata     <= head_d;
            not_empty <= (count_d != '0);
            afull     <= (count_d >= CW'(AFULL_LEVEL));
        end
    end

endmodule

// File: rtl/pe_is_psum_drain.sv
// Bottom-edge psum collector for the input-stationary PE array.
// De-skews the diagonal psum wavefront into aligned rows, buffers them and
// streams them out with valid/ready, back-pressuring the array via stall.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   process_en            array advance strobe; skew and valid pipes shift only on it
//   start, rows_total     frame start pulse and row count latched on it
//   col0_valid, psum_in   column-0 result tag and bottom-row psum bus
//   out_valid/out_ready   result row stream handshake, out_data = aligned row
//   stall                 asks the controller to drop process_en
//   busy                  frame in progress
//   frame_done            single-cycle pulse after the last row of a frame is popped
//   overflow              sticky, a row was dropped into a full FIFO
module pe_is_psum_drain
    import pe_array_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       process_en,
    input  logic                       start,
    input  logic [CNT_WIDTH-1:0]       rows_total,
    input  logic                       col0_valid,
    input  logic [COLS*PSUM_WIDTH-1:0] psum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*PSUM_WIDTH-1:0] out_data,
    output logic                       stall,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow
);

    localparam int unsigned BW = COLS * PSUM_WIDTH;
    localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

    logic [BW-1:0] aligned;
    logic          tag_out;
    logic [FW-1:0] fifo_count;
    logic          push_c, pop_c, fifo_full_c;

    drain_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] rows_q, rows_d;
    logic [CNT_WIDTH-1:0] push_cnt_q, push_cnt_d;
    logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic                 busy_d, done_d, overflow_d;

    // Lane c is delayed COLS-1-c advances so every lane lines up with the last column
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        if (c == COLS - 1) begin : g_pass
            assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] = psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
        end else begin : g_dly
            localparam int unsigned D = COLS - 1 - c;
            logic [PSUM_WIDTH-1:0] pipe_q [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) pipe_q[i] <= '0;
                end else if (process_en) begin
                    pipe_q[0] <= psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
                    for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] = pipe_q[D-1];
        end
    end

    // Result tag follows lane 0 through the same number of advances
    if (COLS > 1) begin : g_tag
        logic [COLS-2:0] tag_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q <= '0;
            end else if (process_en) begin
                tag_q[0] <= col0_valid;
                for (int i = 1; i < COLS - 1; i++) tag_q[i] <= tag_q[i-1];
            end
        end

        assign tag_out = tag_q[COLS-2];
    end else begin : g_tag_pass
        assign tag_out = col0_valid;
    end

    assign pop_c       = out_valid & out_ready;
    assign fifo_full_c = (fifo_count == FW'(FIFO_DEPTH));

    // Stall leaves headroom for the COLS-1 rows still travelling through the skew pipe
    pe_row_fifo #(
        .WIDTH       (BW),
        .DEPTH       (FIFO_DEPTH),
        .AFULL_LEVEL (FIFO_DEPTH - COLS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .wdata     (aligned),
        .pop       (pop_c),
        .rdata     (out_data),
        .not_empty (out_valid),
        .afull     (stall),
        .count     (fifo_count)
    );

    // Frame control: next state, counters and registered-output inputs
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        done_d     = 1'b0;
        push_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d     = rows_total;
                    push_cnt_d = '0;
                    pop_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                push_c = process_en & tag_out;
                if (push_c) begin
                    push_cnt_d = push_cnt_q + CNT_WIDTH'(1);
                    if (push_cnt_d == rows_q) state_d = DRAIN;
                end
                if (pop_c) pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
            end
            DRAIN: begin
                if (pop_c) begin
                    pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
                    if (pop_cnt_d == rows_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        overflow_d = overflow | (push_c & fifo_full_c & ~pop_c);
    end

    // Frame state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            busy       <= busy_d;
            frame_done <= done_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pe_is_psum_drain.sv
// Self-checking bench for pe_is_psum_drain: directed wavefront scenarios plus
// random traffic, compared against a behavioural model of the drain.
module tb_pe_is_psum_drain;

    localparam int unsigned W     = 16;
    localparam int unsigned COLS  = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned BW    = W * COLS;
    localparam int unsigned LAT   = COLS - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            process_en = 1'b0;
    logic            start = 1'b0;
    logic [CNTW-1:0] rows_total = '0;
    logic            col0_valid = 1'b0;
    logic [BW-1:0]   psum_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_data;
    logic            stall, busy, frame_done, overflow;

    pe_is_psum_drain #(
        .PSUM_WIDTH (W),
        .COLS       (COLS),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .process_en (process_en),
        .start      (start),
        .rows_total (rows_total),
        .col0_valid (col0_valid),
        .psum_in    (psum_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall      (stall),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: history of every advance, a row queue and frame bookkeeping
    logic [BW-1:0] hist_bus [0:4095];
    bit            hist_v   [0:4095];
    int            nadv;
    logic [BW-1:0] mq [$];
    bit            m_ovf, m_busy, m_drain, m_done;
    int            m_rows, m_pushed, m_popped;

    logic [BW-1:0] popped_q [$];
    int            cyc = 0;
    int            done_cnt = 0;
    int            first_tag_cyc = -1;
    int            first_out_cyc = -1;
    int            wt, wn;

    function automatic void model_reset();
        nadv     = 0;
        mq.delete();
        m_ovf    = 0;
        m_busy   = 0;
        m_drain  = 0;
        m_done   = 0;
        m_rows   = 0;
        m_pushed = 0;
        m_popped = 0;
    endfunction

    function automatic logic [BW-1:0] exp_row(input int r);
        logic [BW-1:0] row;
        for (int c = 0; c < COLS; c++) row[c*W +: W] = {8'(r), 8'(c)};
        return row;
    endfunction

    // Row from advance k is assembled from lane c of advance k+c
    task automatic model_edge();
        bit            pop, push;
        logic [BW-1:0] row, snap;
        int            n, pre_size, base;
        pop  = (mq.size() > 0) && out_ready;
        push = 0;
        row  = '0;
        if (process_en) begin
            n = nadv;
            hist_bus[n] = psum_in;
            hist_v[n]   = col0_valid;
            nadv++;
            if (n >= int'(LAT)) begin
                base = n - int'(LAT);
                for (int c = 0; c < COLS; c++) begin
                    snap = hist_bus[base + c];
                    row[c*W +: W] = snap[c*W +: W];
                end
                push = hist_v[base] && m_busy && !m_drain;
            end
        end
        m_done   = 0;
        pre_size = mq.size();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (pre_size < int'(DEPTH) || pop) mq.push_back(row);
            else m_ovf = 1;
        end
        if (!m_busy) begin
            if (start) begin
                m_busy   = 1;
                m_drain  = 0;
                m_rows   = int'(rows_total);
                m_pushed = 0;
                m_popped = 0;
            end
        end else if (!m_drain) begin
            if (push) begin
                m_pushed++;
                if (m_pushed == m_rows) m_drain = 1;
            end
            if (pop) m_popped++;
        end else if (pop) begin
            m_popped++;
            if (m_popped == m_rows) begin
                m_busy  = 0;
                m_drain = 0;
                m_done  = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        check("stall", 64'(stall), 64'(mq.size() >= int'(DEPTH - COLS)));
        check("busy", 64'(busy), 64'(m_busy));
        check("frame_done", 64'(frame_done), 64'(m_done));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("fifo_count", 64'(dut.u_fifo.count), 64'(mq.size()));
    endtask

    task automatic step();
        logic          pv, pr;
        logic [BW-1:0] pd;
        pv = out_valid;
        pd = out_data;
        pr = out_ready;
        @(posedge clk);
        cyc++;
        model_edge();
        if (pv && pr) popped_q.push_back(pd);
        #1;
        if (frame_done) done_cnt++;
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        compare_all();
    endtask

    task automatic start_frame(input int rows);
        rows_total = CNTW'(rows);
        start      = 1'b1;
        step();
        start      = 1'b0;
        popped_q.delete();
        done_cnt   = 0;
    endtask

    task automatic wave_begin(input int n);
        wt = 0;
        wn = n;
    endtask

    // Drive the skewed wavefront: row r appears on lane c at advance r+c
    task automatic wave_cycles(input int ncyc, input bit obey, input bit rdy,
                               input int hold_at, input int hold_len);
        for (int k = 0; k < ncyc; k++) begin
            bit en;
            en = !(k >= hold_at && k < hold_at + hold_len);
            if (obey && stall) en = 0;
            process_en = en;
            out_ready  = rdy;
            if (en) begin
                col0_valid = (wt < wn);
                for (int c = 0; c < COLS; c++) begin
                    if (wt - c >= 0 && wt - c < wn) psum_in[c*W +: W] = {8'(wt - c), 8'(c)};
                    else psum_in[c*W +: W] = W'($urandom);
                end
            end else begin
                col0_valid = 1'($urandom);
                psum_in    = {$urandom, $urandom};
            end
            step();
            if (en && col0_valid && first_tag_cyc < 0) first_tag_cyc = cyc;
            if (en) wt++;
            start = 1'b0;
        end
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        model_reset();
        start      = 1'b0;
        process_en = 1'b0;
        col0_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        repeat (4) step();
        check("rst_no_done", 64'(done_cnt), 64'd0);
    endtask

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bit en;
            start      = ($urandom % 12) == 0;
            rows_total = CNTW'(1 + $urandom % 5);
            col0_valid = 1'($urandom);
            psum_in    = {$urandom, $urandom};
            out_ready  = ($urandom % 4) != 0;
            en         = ($urandom % 4) != 0;
            if (stall && ($urandom % 8) != 0) en = 0;
            process_en = en;
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ids_bad;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Alignment and first-row latency
        start_frame(3);
        first_tag_cyc = -1;
        first_out_cyc = -1;
        wave_begin(3);
        wave_cycles(12, 0, 1, 99, 0);
        check("align_latency", 64'(first_out_cyc - first_tag_cyc), 64'd3);
        check("align_rows", 64'(popped_q.size()), 64'd3);
        for (int r = 0; r < 3 && r < popped_q.size(); r++) check("align_row", popped_q[r], exp_row(r));
        check("align_done", 64'(done_cnt), 64'd1);

        // Hold process_en low mid-wavefront
        start_frame(3);
        wave_begin(3);
        wave_cycles(16, 0, 1, 2, 5);
        check("hold_rows", 64'(popped_q.size()), 64'd3);
        for (int r = 0; r < 3 && r < popped_q.size(); r++) check("hold_row", popped_q[r], exp_row(r));
        check("hold_done", 64'(done_cnt), 64'd1);

        // Backpressure with a controller that obeys stall
        start_frame(8);
        wave_begin(8);
        wave_cycles(30, 1, 0, 99, 0);
        check("bp_stall", 64'(stall), 64'd1);
        check("bp_count", 64'(dut.u_fifo.count), 64'd4);
        check("bp_overflow", 64'(overflow), 64'd0);
        wave_cycles(30, 1, 1, 99, 0);
        check("bp_rows", 64'(popped_q.size()), 64'd8);
        for (int r = 0; r < 8 && r < popped_q.size(); r++) check("bp_row", popped_q[r], exp_row(r));
        check("bp_done", 64'(done_cnt), 64'd1);
        check("bp_overflow_end", 64'(overflow), 64'd0);

        // Overflow while ignoring stall, then push/pop at full
        start_frame(20);
        wave_begin(16);
        wave_cycles(14, 0, 0, 99, 0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_full", 64'(dut.u_fifo.count), 64'd8);
        wave_cycles(5, 0, 1, 99, 0);
        check("ovf_full_pushpop", 64'(dut.u_fifo.count), 64'd8);
        wave_cycles(5, 0, 1, 99, 0);
        check("ovf_popped", 64'(popped_q.size()), 64'd10);
        ids_bad = 0;
        foreach (popped_q[i]) begin
            logic [BW-1:0] pr;
            pr = popped_q[i];
            if (pr[15:8] >= 8'd8 && pr[15:8] <= 8'd10) ids_bad++;
        end
        check("ovf_dropped_absent", 64'(ids_bad), 64'd0);
        if (popped_q.size() > 8) check("ovf_order", popped_q[8], exp_row(11));
        mid_reset();

        // Frame control: fewer rows than tags, start while busy, then a fresh frame
        start_frame(2);
        wave_begin(3);
        wave_cycles(2, 0, 1, 99, 0);
        rows_total = CNTW'(5);
        start      = 1'b1;
        wave_cycles(1, 0, 1, 99, 0);
        wave_cycles(12, 0, 1, 99, 0);
        check("frame_rows", 64'(popped_q.size()), 64'd2);
        for (int r = 0; r < 2 && r < popped_q.size(); r++) check("frame_row", popped_q[r], exp_row(r));
        check("frame_done_pulses", 64'(done_cnt), 64'd1);
        check("frame_idle", 64'(busy), 64'd0);
        start_frame(1);
        wave_begin(1);
        wave_cycles(10, 0, 1, 99, 0);
        check("frame2_rows", 64'(popped_q.size()), 64'd1);
        if (popped_q.size() > 0) check("frame2_row", popped_q[0], exp_row(0));
        check("frame2_done", 64'(done_cnt), 64'd1);

        // Random traffic against the model, with a reset in the middle
        random_cycles(400);
        mid_reset();
        random_cycles(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
